// File: rtl/sr_mdu_pkg.sv
// Shared types and opcode classification helpers for the M-extension multiply/divide unit.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package sr_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FIX
    } div_state_t;

    function automatic logic is_mul(op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_signed_a(op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic returns_high(op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic returns_rem(op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/sr_div_iter.sv
// Restoring radix-2 divider: done WIDTH+1 cycles after start, or 1 cycle for /0 and signed overflow.
// No backpressure: done is a one-cycle pulse; clear_i returns the FSM to idle on the next edge.
module sr_div_iter
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             clear_i,
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, fres_q, fres_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, rsel_q, rsel_d, fast_q, fast_d;

    logic             sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        fres_d  = fres_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        rsel_d  = rsel_q;
        fast_d  = fast_q;
        sa      = is_signed_a(op_i) & a_i[WIDTH-1];
        sb      = is_signed_b(op_i) & b_i[WIDTH-1];
        // Negating MIN_INT wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
        abs_a   = sa ? -a_i : a_i;
        abs_b   = sb ? -b_i : b_i;
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    rsel_d = returns_rem(op_i);
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    dvs_d  = abs_b;
                    quo_d  = abs_a;
                    rem_d  = '0;
                    cnt_d  = '0;
                    fast_d = 1'b1;
                    if (b_i == '0) begin
                        fres_d  = returns_rem(op_i) ? a_i : '1;
                        state_d = DIV_FIX;
                    end else if (is_signed_b(op_i) && a_i == MIN_INT && b_i == '1) begin
                        fres_d  = returns_rem(op_i) ? '0 : MIN_INT;
                        state_d = DIV_FIX;
                    end else begin
                        fast_d  = 1'b0;
                        state_d = DIV_ITER;
                    end
                end
            end
            DIV_ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH-1)) state_d = DIV_FIX;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (clear_i) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            fres_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rsel_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            fres_q  <= fres_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rsel_q  <= rsel_d;
            fast_q  <= fast_d;
        end
    end

    assign q_fix  = qneg_q ? -quo_q : quo_q;
    assign r_fix  = rneg_q ? -rem_q : rem_q;
    assign done_o = (state_q == DIV_FIX);
    assign res_o  = fast_q ? fres_q : (rsel_q ? r_fix : q_fix);

endmodule

// File: rtl/sr_mdu_m.sv
// RISC-V M-extension unit: MUL* result after MUL_LATENCY cycles, DIV/REM after WIDTH+1 (or 1 on fast path).
// One op in flight: src_rdy drops while busy or during a flush; result_vld is a one-cycle pulse.
module sr_mdu_m
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       op,
    input  logic             src_vld,
    input  logic             src_clear,
    output logic             src_rdy,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_vld
);
    op_t                 op_v;
    logic                accept, mul_start, div_start, div_done;
    logic [WIDTH-1:0]    div_res, mul_res, out_val;
    logic [2*WIDTH-1:0]  ma, mb, prod;

    logic                busy_q, busy_d;
    logic [WIDTH-1:0]    hold_q, hold_d;
    logic                mul_vld_q  [MUL_LATENCY];
    logic                mul_vld_d  [MUL_LATENCY];
    op_t                 mul_op_q   [MUL_LATENCY];
    op_t                 mul_op_d   [MUL_LATENCY];
    logic [2*WIDTH-1:0]  mul_prod_q [MUL_LATENCY];
    logic [2*WIDTH-1:0]  mul_prod_d [MUL_LATENCY];

    assign op_v      = op_t'(op);
    assign src_rdy   = ~busy_q & ~src_clear;
    assign busy      = busy_q;
    assign accept    = src_vld & src_rdy;
    assign mul_start = accept & is_mul(op_v);
    assign div_start = accept & ~is_mul(op_v);

    // Sign/zero-extending to 2*WIDTH makes the truncated product exact for every signedness mix.
    assign ma   = {{WIDTH{is_signed_a(op_v) & srcA[WIDTH-1]}}, srcA};
    assign mb   = {{WIDTH{is_signed_b(op_v) & srcB[WIDTH-1]}}, srcB};
    assign prod = ma * mb;

    always_comb begin
        mul_vld_d[0]  = mul_start;
        mul_op_d[0]   = op_v;
        mul_prod_d[0] = prod;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_op_d[i]   = mul_op_q[i-1];
            mul_prod_d[i] = mul_prod_q[i-1];
        end
        if (src_clear) begin
            for (int i = 0; i < MUL_LATENCY; i++) mul_vld_d[i] = 1'b0;
        end
    end

    sr_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .reset   (reset),
        .start_i (div_start),
        .clear_i (src_clear),
        .op_i    (op_v),
        .a_i     (srcA),
        .b_i     (srcB),
        .done_o  (div_done),
        .res_o   (div_res)
    );

    assign mul_res    = returns_high(mul_op_q[MUL_LATENCY-1])
                        ? mul_prod_q[MUL_LATENCY-1][2*WIDTH-1:WIDTH]
                        : mul_prod_q[MUL_LATENCY-1][WIDTH-1:0];
    assign result_vld = mul_vld_q[MUL_LATENCY-1] | div_done;
    assign out_val    = mul_vld_q[MUL_LATENCY-1] ? mul_res : div_res;
    assign result     = result_vld ? out_val : hold_q;

    always_comb begin
        hold_d = result_vld ? out_val : hold_q;
        busy_d = busy_q;
        if (accept)          busy_d = 1'b1;
        else if (result_vld) busy_d = 1'b0;
        if (src_clear)       busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            hold_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                mul_vld_q[i]  <= 1'b0;
                mul_op_q[i]   <= OP_MUL;
                mul_prod_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            hold_q <= hold_d;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                mul_vld_q[i]  <= mul_vld_d[i];
                mul_op_q[i]   <= mul_op_d[i];
                mul_prod_q[i] <= mul_prod_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sr_mdu_m.sv
// Bench for sr_mdu_m: directed M-op cases, flush/reset aborts, and random ops vs an arithmetic model
// across four configurations (32/L2, 32/L3, 8/L1, 32/L4).
module tb_sr_mdu_m;
    logic        clk = 1'b0;
    logic [31:0] a_s, b_s;
    logic [2:0]  op_s;
    logic        vld [4];
    logic        clr [4];
    logic        rst [4];
    logic        rdy [4];
    logic        bsy [4];
    logic        rv  [4];
    logic [31:0] res [4];
    logic [7:0]  res8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sr_mdu_m #(.WIDTH(32), .MUL_LATENCY(2)) d0 (
        .clk(clk), .reset(rst[0]), .srcA(a_s), .srcB(b_s), .op(op_s), .src_vld(vld[0]),
        .src_clear(clr[0]), .src_rdy(rdy[0]), .busy(bsy[0]), .result(res[0]), .result_vld(rv[0]));
    sr_mdu_m #(.WIDTH(32), .MUL_LATENCY(3)) d1 (
        .clk(clk), .reset(rst[1]), .srcA(a_s), .srcB(b_s), .op(op_s), .src_vld(vld[1]),
        .src_clear(clr[1]), .src_rdy(rdy[1]), .busy(bsy[1]), .result(res[1]), .result_vld(rv[1]));
    sr_mdu_m #(.WIDTH(8), .MUL_LATENCY(1)) d2 (
        .clk(clk), .reset(rst[2]), .srcA(a_s[7:0]), .srcB(b_s[7:0]), .op(op_s), .src_vld(vld[2]),
        .src_clear(clr[2]), .src_rdy(rdy[2]), .busy(bsy[2]), .result(res8), .result_vld(rv[2]));
    sr_mdu_m #(.WIDTH(32), .MUL_LATENCY(4)) d3 (
        .clk(clk), .reset(rst[3]), .srcA(a_s), .srcB(b_s), .op(op_s), .src_vld(vld[3]),
        .src_clear(clr[3]), .src_rdy(rdy[3]), .busy(bsy[3]), .result(res[3]), .result_vld(rv[3]));

    assign res[2] = {24'b0, res8};

    function automatic int wid(int k);
        return (k == 2) ? 8 : 32;
    endfunction

    function automatic int mlat(int k);
        case (k)
            0:       return 2;
            1:       return 3;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Arithmetic reference: RISC-V M semantics on w-bit values, using 64-bit integers.
    function automatic logic [31:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b, int w);
        longint unsigned mask, ua, ub;
        longint          sa, sb, smin;
        logic [63:0]     p;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        smin = -(longint'(1) << (w-1));
        case (o)
            3'd0: p = ua * ub;
            3'd1: p = (64'(sa * sb)) >> w;
            3'd2: p = (64'(sa * longint'(ub))) >> w;
            3'd3: p = (ua * ub) >> w;
            3'd4: p = (ub == 0) ? mask : ((sa == smin && sb == -1) ? ua : 64'(sa / sb));
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: p = (ub == 0) ? ua : ((sa == smin && sb == -1) ? 64'd0 : 64'(sa % sb));
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    function automatic int ref_lat(int k, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint unsigned mask, ua, ub;
        int w;
        w    = wid(k);
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        if (o < 3'd4) return mlat(k);
        if (ub == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && ua == (64'd1 << (w-1)) && ub == mask) return 1;
        return w + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op on instance k as soon as it is ready, then check result, latency and pulse shape.
    task automatic do_op(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat, input string tag);
        int          n;
        int          got_lat;
        logic [31:0] got_r;
        n = 0;
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 32'(rdy[k]), 32'd1);
        op_s   = o;
        a_s    = a;
        b_s    = b;
        vld[k] = 1'b1;
        @(posedge clk);
        #1 vld[k] = 1'b0;
        got_lat = -1;
        got_r   = 'x;
        for (int i = 1; i <= exp_lat + 8; i++) begin
            @(negedge clk);
            chk({tag, "_rdy_busy"}, 32'(rdy[k] & bsy[k]), 32'd0);
            if (i == 1) chk({tag, "_busy"}, 32'(bsy[k]), 32'd1);
            if (rv[k]) begin
                got_lat = i;
                got_r   = res[k];
                break;
            end
        end
        chk({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        chk({tag, "_res"}, got_r, exp_r);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rv[k]), 32'd0);
        chk({tag, "_hold"}, res[k], got_r);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [2:0]  o;
        logic [31:0] a, b, msk;
        int          w;

        a_s = '0; b_s = '0; op_s = '0;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0; clr[k] = 1'b0; rst[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_res%0d", k), res[k], 32'd0);
            chk($sformatf("rst_vld%0d", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 32'd1);
        end

        do_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, "mul");
        do_op(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, "mulh");
        do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "mulhu");
        do_op(0, 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 2, "mulhsu");

        do_op(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
        do_op(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
        do_op(0, 3'd5, 32'd100, 32'd7, 32'h0000000E, 33, "divu");
        do_op(0, 3'd7, 32'd100, 32'd7, 32'h00000002, 33, "remu");

        do_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_z");
        do_op(0, 3'd6, 32'd5, 32'd0, 32'h00000005, 1, "rem_z");
        do_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        do_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");

        // Flush a divide 10 cycles in, with a competing request in the flush cycle.
        op_s = 3'd4; a_s = 32'd1000; b_s = 32'd3; vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rv[0]) seen++;
        end
        clr[0] = 1'b1; vld[0] = 1'b1; op_s = 3'd0; a_s = 32'd2; b_s = 32'd2;
        #1 chk("clr_rdy", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #1 begin clr[0] = 1'b0; vld[0] = 1'b0; end
        @(negedge clk);
        chk("clr_busy", 32'(bsy[0]), 32'd0);
        chk("clr_rdy_after", 32'(rdy[0]), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv[0]) seen++;
        end
        chk("clr_no_vld", 32'(seen), 32'd0);
        do_op(0, 3'd0, 32'd3, 32'd4, 32'h0000000C, 2, "mul_after_clr");

        // Reset in the middle of a 3-cycle multiply.
        do_op(1, 3'd0, 32'd3, 32'd5, 32'd15, 3, "mul_l3");
        op_s = 3'd0; a_s = 32'd6; b_s = 32'd7; vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rv[1]) seen++;
        end
        chk("rstmid_no_vld", 32'(seen), 32'd0);
        chk("rstmid_res", res[1], 32'd0);
        chk("rstmid_rdy", 32'(rdy[1]), 32'd1);
        chk("rstmid_busy", 32'(bsy[1]), 32'd0);

        // Random back-to-back traffic, biased towards the divide corner cases.
        for (int k = 0; k < 4; k++) begin
            if (k == 1) continue;
            w   = wid(k);
            msk = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
            for (int i = 0; i < 50; i++) begin
                o = 3'($urandom_range(0, 7));
                a = $urandom & msk;
                b = $urandom & msk;
                case ($urandom_range(0, 9))
                    0: b = 32'd0;
                    1: begin a = 32'd1 << (w - 1); b = msk; end
                    2: b = 32'($urandom_range(1, 9));
                    3: a = 32'd1 << (w - 1);
                    default: ;
                endcase
                do_op(k, o, a, b, ref_res(o, a, b, w), ref_lat(k, o, a, b), $sformatf("rnd%0d_%0d", k, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
